// File: rtl/keccak_driver.sv
// Host-side driver for the keccak core: serializes header, length and message words
// onto the core input, then drains the digest through a 2-entry skid FIFO.
package keccak_pkg;
    localparam int unsigned w = 64;
endpackage

module keccak_driver #(
    parameter int unsigned W = keccak_pkg::w
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_mode,
    input  logic [31:0]  cmd_in_bits,
    input  logic [31:0]  cmd_out_bits,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [W-1:0] msg_data,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [W-1:0] dig_data,
    output logic         dig_last,
    output logic         busy,
    output logic         done,
    output logic         k_valid_n,
    input  logic         k_ready,
    output logic [W-1:0] k_data,
    input  logic         k_out_valid,
    output logic         k_out_ready_n,
    input  logic [W-1:0] k_out_data
);
    localparam int unsigned CW = 27;
    localparam int unsigned FD = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_MSG,
        S_DIG,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    mode_q;
    logic [31:0]   in_bits_q;
    logic [31:0]   out_bits_q;
    logic [CW-1:0] in_rem_q;
    logic [CW-1:0] out_words_q;
    logic [CW-1:0] req_rem_q, req_rem_d;
    logic [CW-1:0] dlv_q;
    logic [CW-1:0] cmd_in_words;
    logic [CW-1:0] cmd_out_words;
    logic [W-1:0]  fifo_q [FD];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    cnt_q, cnt_d;
    logic          accept, msg_xfer, push, pop;

    // Bit counts rounded up to whole 64-bit words, summed at 33 bits to avoid wrap
    assign cmd_in_words  = CW'((33'(cmd_in_bits)  + 33'd63) >> 6);
    assign cmd_out_words = CW'((33'(cmd_out_bits) + 33'd63) >> 6);

    assign push      = k_out_valid && !k_out_ready_n;
    assign pop       = dig_valid && dig_ready;
    assign cnt_d     = cnt_q + 2'(push) - 2'(pop);
    assign req_rem_d = accept ? cmd_out_words : (req_rem_q - CW'(push));

    assign dig_valid = (cnt_q != 2'd0);
    assign dig_data  = fifo_q[rd_ptr_q];
    assign dig_last  = dig_valid && (dlv_q == (out_words_q - CW'(1)));

    // Next-state and handshake decode
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        msg_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        k_valid_n = 1'b1;
        k_data    = '0;
        accept    = 1'b0;
        msg_xfer  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                busy      = 1'b1;
                k_valid_n = 1'b0;
                k_data    = W'({mode_q, 30'b0, out_bits_q});
                if (k_ready) state_d = S_LEN;
            end
            S_LEN: begin
                busy      = 1'b1;
                k_valid_n = 1'b0;
                k_data    = W'({32'b0, in_bits_q});
                if (k_ready) state_d = (in_rem_q != '0) ? S_MSG : S_DIG;
            end
            S_MSG: begin
                busy      = 1'b1;
                k_data    = msg_data;
                k_valid_n = !msg_valid;
                msg_ready = k_ready;
                if (msg_valid && k_ready) begin
                    msg_xfer = 1'b1;
                    if (in_rem_q == CW'(1)) state_d = S_DIG;
                end
            end
            S_DIG: begin
                busy = 1'b1;
                if ((out_words_q == '0) || (pop && dig_last)) state_d = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, job registers and the registered core-output ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            mode_q        <= '0;
            in_bits_q     <= '0;
            out_bits_q    <= '0;
            in_rem_q      <= '0;
            out_words_q   <= '0;
            req_rem_q     <= '0;
            dlv_q         <= '0;
            k_out_ready_n <= 1'b1;
        end else begin
            state_q       <= state_d;
            req_rem_q     <= req_rem_d;
            k_out_ready_n <= !((state_d == S_DIG) && (cnt_d < 2'd2) && (req_rem_d != '0));
            if (accept) begin
                mode_q      <= cmd_mode;
                in_bits_q   <= cmd_in_bits;
                out_bits_q  <= cmd_out_bits;
                in_rem_q    <= cmd_in_words;
                out_words_q <= cmd_out_words;
                dlv_q       <= '0;
            end else begin
                if (msg_xfer) in_rem_q <= in_rem_q - CW'(1);
                if (pop)      dlv_q    <= dlv_q + CW'(1);
            end
        end
    end

    // Two-entry skid FIFO between core output and digest stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= k_out_data;
                wr_ptr_q         <= !wr_ptr_q;
            end
            if (pop) rd_ptr_q <= !rd_ptr_q;
        end
    end
endmodule

// File: tb/tb_keccak_driver.sv
// Directed bench for keccak_driver: drives command, message and core handshakes
// and checks every transfer against hand-computed words.
module tb_keccak_driver;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [31:0] cmd_in_bits;
    logic [31:0] cmd_out_bits;
    logic        msg_valid;
    logic        msg_ready;
    logic [63:0] msg_data;
    logic        dig_valid;
    logic        dig_ready;
    logic [63:0] dig_data;
    logic        dig_last;
    logic        busy;
    logic        done;
    logic        k_valid_n;
    logic        k_ready;
    logic [63:0] k_data;
    logic        k_out_valid;
    logic        k_out_ready_n;
    logic [63:0] k_out_data;

    int tests = 0;
    int fails = 0;

    keccak_driver #(.W(64)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_in_bits(cmd_in_bits), .cmd_out_bits(cmd_out_bits),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data), .dig_last(dig_last),
        .busy(busy), .done(done),
        .k_valid_n(k_valid_n), .k_ready(k_ready), .k_data(k_data),
        .k_out_valid(k_out_valid), .k_out_ready_n(k_out_ready_n), .k_out_data(k_out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mword(input int i);
        return 64'hC0DE_0000_0000_0000 + 64'(i);
    endfunction

    function automatic logic [63:0] dword(input int i);
        return 64'hD16E_5700_0000_0000 + 64'(i);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input string name, input logic [1:0] mode,
                           input logic [31:0] in_bits, input logic [31:0] out_bits,
                           input logic [63:0] exp_hdr, input logic [63:0] exp_len,
                           input int exp_in_w, input int exp_out_w, input bit kr_toggle,
                           input int stall_at, input int stall_len, input int exp_peak);
        int cyc, in_cnt, msg_cnt, mrdy_seen, core_idx, dig_idx;
        int last_cyc, first_msg, first_push, first_dv, peak, ornh;
        bit finished;
        logic [63:0] exp_k;
        cyc = 0; in_cnt = 0; msg_cnt = 0; mrdy_seen = 0; core_idx = 0; dig_idx = 0;
        last_cyc = -1; first_msg = -1; first_push = -1; first_dv = -1; peak = 0; ornh = 0;
        finished = 1'b0;
        cmd_valid = 1'b1; cmd_mode = mode; cmd_in_bits = in_bits; cmd_out_bits = out_bits;
        k_ready = 1'b1; msg_valid = 1'b1; msg_data = mword(0);
        k_out_valid = 1'b1; k_out_data = dword(0); dig_ready = 1'b1;
        while (!finished && cyc < 200) begin
            @(negedge clk);
            if (cyc == 0) check({name, "/cmd_ready_c0"}, 64'(cmd_ready), 64'd1);
            if (cyc == 1) begin
                check({name, "/cmd_ready_c1"}, 64'(cmd_ready), 64'd0);
                check({name, "/busy_c1"}, 64'(busy), 64'd1);
                check({name, "/hdr_valid_n_c1"}, 64'(k_valid_n), 64'd0);
            end
            if (!k_valid_n && k_ready) begin
                exp_k = (in_cnt == 0) ? exp_hdr : (in_cnt == 1) ? exp_len : mword(in_cnt - 2);
                check({name, "/k_data"}, k_data, exp_k);
                in_cnt++;
            end
            if (msg_ready) mrdy_seen++;
            if (msg_valid && msg_ready) begin
                if (first_msg < 0) first_msg = cyc;
                msg_cnt++;
            end
            if (dig_valid && first_dv < 0) first_dv = cyc;
            if (k_out_ready_n && core_idx > 0 && core_idx < exp_out_w) ornh++;
            if (k_out_valid && !k_out_ready_n) begin
                if (first_push < 0) first_push = cyc;
                core_idx++;
            end
            if (dig_valid && dig_ready) begin
                check({name, "/dig_data"}, dig_data, dword(dig_idx));
                check({name, "/dig_last"}, 64'(dig_last), 64'(dig_idx == exp_out_w - 1));
                if (dig_idx == exp_out_w - 1) last_cyc = cyc;
                dig_idx++;
            end
            if (core_idx - dig_idx > peak) peak = core_idx - dig_idx;
            if (done) begin
                check({name, "/done_cycle"}, 64'(cyc), 64'(last_cyc + 1));
                check({name, "/busy_at_done"}, 64'(busy), 64'd0);
                finished = 1'b1;
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            if (kr_toggle) k_ready = !k_ready;
            msg_data   = mword(msg_cnt);
            k_out_data = dword(core_idx);
            dig_ready  = !((cyc + 1 >= stall_at) && (cyc + 1 < stall_at + stall_len));
            cyc++;
        end
        check({name, "/finished"}, 64'(finished), 64'd1);
        check({name, "/in_xfers"}, 64'(in_cnt), 64'(2 + exp_in_w));
        check({name, "/msg_xfers"}, 64'(msg_cnt), 64'(exp_in_w));
        if (exp_in_w == 0) check({name, "/msg_ready_seen"}, 64'(mrdy_seen), 64'd0);
        if (!kr_toggle && exp_in_w > 0) check({name, "/first_msg_cyc"}, 64'(first_msg), 64'd3);
        check({name, "/core_out_xfers"}, 64'(core_idx), 64'(exp_out_w));
        check({name, "/dig_words"}, 64'(dig_idx), 64'(exp_out_w));
        check({name, "/dig_latency"}, 64'(first_dv), 64'(first_push + 1));
        check({name, "/fifo_peak"}, 64'(peak), 64'(exp_peak));
        if (stall_len > 0) check({name, "/ready_n_backpressure"}, 64'(ornh > 0), 64'd1);
        @(negedge clk);
        check({name, "/idle_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({name, "/idle_busy"}, 64'(busy), 64'd0);
        check({name, "/idle_dig_valid"}, 64'(dig_valid), 64'd0);
        check({name, "/idle_k_out_ready_n"}, 64'(k_out_ready_n), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int cyc;
        rst = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_in_bits = '0; cmd_out_bits = '0;
        msg_valid = 1'b0; msg_data = '0; dig_ready = 1'b0; k_ready = 1'b1;
        k_out_valid = 1'b0; k_out_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset/msg_ready", 64'(msg_ready), 64'd0);
        check("reset/dig_valid", 64'(dig_valid), 64'd0);
        check("reset/dig_last", 64'(dig_last), 64'd0);
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/k_valid_n", 64'(k_valid_n), 64'd1);
        check("reset/k_out_ready_n", 64'(k_out_ready_n), 64'd1);
        check("reset/k_data", k_data, 64'd0);
        check("reset/dig_data", dig_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1; msg_valid = 1'b1; k_out_valid = 1'b1; k_out_data = 64'hBAD0_BAD0_BAD0_BAD0;

        // Core output presented while idle must be ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle/k_out_ready_n", 64'(k_out_ready_n), 64'd1);
            check("idle/dig_valid", 64'(dig_valid), 64'd0);
        end
        @(posedge clk); #1;

        run_job("shake128", 2'd0, 32'd128, 32'd256, 64'h0000_0000_0000_0100, 64'h0000_0000_0000_0080,
                2, 4, 1'b0, -1, 0, 1);
        run_job("empty", 2'd2, 32'd0, 32'd64, 64'h8000_0000_0000_0040, 64'h0000_0000_0000_0000,
                0, 1, 1'b0, -1, 0, 1);
        run_job("in_stall", 2'd1, 32'd320, 32'd128, 64'h4000_0000_0000_0080, 64'h0000_0000_0000_0140,
                5, 2, 1'b1, -1, 0, 1);
        run_job("dig_bp", 2'd3, 32'd64, 32'd512, 64'hC000_0000_0000_0200, 64'h0000_0000_0000_0040,
                1, 8, 1'b0, 7, 10, 2);

        // Abort in the middle of the message phase
        cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_in_bits = 32'd320; cmd_out_bits = 32'd64;
        k_ready = 1'b1; msg_valid = 1'b1; msg_data = mword(0); dig_ready = 1'b1;
        n = 0; cyc = 0;
        while (n < 3 && cyc < 20) begin
            @(negedge clk);
            if (msg_valid && msg_ready) n++;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            msg_data  = mword(n);
            cyc++;
        end
        check("rst_mid/msg_xfers", 64'(n), 64'd3);
        #1;
        check("rst_mid/pre_k_valid_n", 64'(k_valid_n), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_mid/k_valid_n", 64'(k_valid_n), 64'd1);
        check("rst_mid/msg_ready", 64'(msg_ready), 64'd0);
        check("rst_mid/cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_mid/busy", 64'(busy), 64'd0);
        check("rst_mid/k_out_ready_n", 64'(k_out_ready_n), 64'd1);
        check("rst_mid/k_data", k_data, 64'd0);
        check("rst_mid/dig_valid", 64'(dig_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_job("partial", 2'd0, 32'd8, 32'd65, 64'h0000_0000_0000_0041, 64'h0000_0000_0000_0008,
                1, 2, 1'b0, -1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
